// File: rtl/div_seq.sv
// Multi-cycle 32-bit restoring divider for the EX stage: stalls EX while busy, returns quotient/remainder with a one-cycle done strobe.
// Optional macro DIV_SIGNED_EN compiles in the signed DIV path (operand/result negation).
module div_seq (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_signed_div,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  input  logic        i_annul,
  output logic        o_stall_req,
  output logic        o_done,
  output logic [31:0] o_result_hi,
  output logic [31:0] o_result_lo,
  output logic        o_div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_ZERO, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [32:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [4:0]  r_cnt;
  logic        r_fin;
  logic        r_done;
  logic        r_div_zero;
  logic [31:0] r_result_hi;
  logic [31:0] r_result_lo;

  logic        w_accept;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;
  logic [33:0] w_shift, w_diff;
  logic        w_ge;
  logic [32:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [31:0] w_lo_fix, w_hi_fix;

  assign w_accept = (r_state == S_IDLE) && i_start && !i_annul;

`ifdef DIV_SIGNED_EN
  logic r_q_neg, r_r_neg;
  assign w_a_neg  = i_signed_div & i_dividend[31];
  assign w_b_neg  = i_signed_div & i_divisor[31];
  assign w_a_mag  = w_a_neg ? (~i_dividend + 32'd1) : i_dividend;
  assign w_b_mag  = w_b_neg ? (~i_divisor + 32'd1) : i_divisor;
  assign w_lo_fix = r_q_neg ? (~r_quo + 32'd1) : r_quo;
  assign w_hi_fix = r_r_neg ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if (w_accept) begin
      r_q_neg <= w_a_neg ^ w_b_neg;
      r_r_neg <= w_a_neg;
    end
  end
`else
  logic w_unused_signed;
  assign w_unused_signed = i_signed_div;
  assign w_a_neg  = 1'b0;
  assign w_b_neg  = 1'b0;
  assign w_a_mag  = i_dividend;
  assign w_b_mag  = i_divisor;
  assign w_lo_fix = r_quo;
  assign w_hi_fix = r_rem[31:0];
`endif

  // rem < divisor holds between iterations, so a 34-bit subtract gives a clean sign bit
  assign w_shift  = {r_rem, r_quo[31]};
  assign w_diff   = w_shift - {2'b00, r_dvs};
  assign w_ge     = ~w_diff[33];
  assign w_rem_nx = w_ge ? w_diff[32:0] : w_shift[32:0];
  assign w_quo_nx = {r_quo[30:0], w_ge};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_stall_req = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_stall_req = w_accept;
        if (w_accept) w_next = (i_divisor == 32'd0) ? S_ZERO : S_DIVIDE;
      end
      S_DIVIDE: begin
        o_stall_req = 1'b1;
        if (i_annul)    w_next = S_IDLE;
        else if (r_fin) w_next = S_DONE;
      end
      S_ZERO: begin
        o_stall_req = 1'b1;
        w_next      = i_annul ? S_IDLE : S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // After the 32nd iteration one extra DIVIDE cycle applies the sign fix-up into the result registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_fin       <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
      r_result_hi <= '0;
      r_result_lo <= '0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && (i_divisor != 32'd0)) begin
            r_rem <= '0;
            r_quo <= w_a_mag;
            r_dvs <= w_b_mag;
            r_cnt <= '0;
            r_fin <= 1'b0;
          end
        end
        S_DIVIDE: begin
          if (!i_annul) begin
            if (!r_fin) begin
              r_rem <= w_rem_nx;
              r_quo <= w_quo_nx;
              r_cnt <= r_cnt + 5'd1;
              r_fin <= (r_cnt == 5'd31);
            end else begin
              r_result_hi <= w_hi_fix;
              r_result_lo <= w_lo_fix;
              r_done      <= 1'b1;
            end
          end
        end
        S_ZERO: begin
          if (!i_annul) begin
            r_result_hi <= '0;
            r_result_lo <= '0;
            r_done      <= 1'b1;
            r_div_zero  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_done      = r_done;
  assign o_div_zero  = r_div_zero;
  assign o_result_hi = r_result_hi;
  assign o_result_lo = r_result_lo;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: scoreboard of behavioural expected results, latency/stall counting, annul and reset aborts.
module tb_div_seq;

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        annul = 1'b0;
  logic        stall_req, done, div_zero;
  logic [31:0] result_hi, result_lo;

  res_t        sb[$];
  int          n_pass = 0;
  int          n_tot  = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  div_seq dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_signed_div (signed_div),
    .i_dividend   (dividend),
    .i_divisor    (divisor),
    .i_annul      (annul),
    .o_stall_req  (stall_req),
    .o_done       (done),
    .o_result_hi  (result_hi),
    .o_result_lo  (result_lo),
    .o_div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic sa, sbn;
    logic [31:0] ma, mb, q, m;
    if (b == 32'd0) begin
      r.hi = '0; r.lo = '0; r.dz = 1'b1;
      return r;
    end
    sa  = sg & a[31] & SIGNED_EN;
    sbn = sg & b[31] & SIGNED_EN;
    ma  = sa  ? (~a + 32'd1) : a;
    mb  = sbn ? (~b + 32'd1) : b;
    q   = ma / mb;
    m   = ma % mb;
    r.lo = (sa ^ sbn) ? (~q + 32'd1) : q;
    r.hi = sa ? (~m + 32'd1) : m;
    r.dz = 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tot++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  // caller is at a negedge; operands are sampled at the next posedge
  task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b, input bit push);
    start = 1'b1; signed_div = sg; dividend = a; divisor = b;
    if (push) sb.push_back(model(sg, a, b));
  endtask

  task automatic wait_done(input string tag, input int lat, input bit hold);
    res_t e;
    int   stl;
    bit   seen;
    #1;
    stl  = stall_req ? 1 : 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 60 && !seen; cyc++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      if (done) begin
        seen = 1'b1;
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_stall_cycles"}, stl, lat + 1);
        if (hold) chk({tag, "_stall_in_done"}, {31'd0, stall_req}, 32'd0);
        if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk({tag, "_hi"}, result_hi, e.hi);
          chk({tag, "_lo"}, result_lo, e.lo);
          chk({tag, "_dz"}, {31'd0, div_zero}, {31'd0, e.dz});
          exp_hi = e.hi; exp_lo = e.lo;
        end
      end else if (stall_req) stl++;
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (!hold) begin
      @(negedge clk);
      chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, "_dz_pulse"}, {31'd0, div_zero}, 32'd0);
    end
  endtask

  task automatic no_done_window(input string tag, input int cycles);
    int n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk({tag, "_no_done"}, n, 0);
    chk({tag, "_hi_kept"}, result_hi, exp_hi);
    chk({tag, "_lo_kept"}, result_lo, exp_lo);
  endtask

  initial begin
    #1;
    chk("rst_hi", result_hi, 32'd0);
    chk("rst_lo", result_lo, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    @(negedge clk); issue(0, 32'd100, 32'd7, 1);           wait_done("divu_100_7", 33, 0);
    @(negedge clk); issue(1, 32'hFFFF_FFF9, 32'd2, 1);     wait_done("div_m7_2", 33, 0);
    @(negedge clk); issue(1, 32'd7, 32'hFFFF_FFFE, 1);     wait_done("div_7_m2", 33, 0);
    @(negedge clk); issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done("div_ovf", 33, 0);
    @(negedge clk); issue(0, 32'h1234, 32'd0, 1);          wait_done("div_zero", 1, 0);

    // annul together with start in IDLE: no start, no stall
    @(negedge clk); issue(0, 32'd50, 32'd5, 0); annul = 1'b1;
    #1 chk("annul_idle_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    chk("annul_idle_stall2", {31'd0, stall_req}, 32'd0);
    start = 1'b0; annul = 1'b0;
    no_done_window("annul_idle", 5);

    // annul after 10 iterations
    @(negedge clk); issue(0, 32'hFFFF_FFFF, 32'd3, 0);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 10) annul = 1'b1;
    end
    @(negedge clk);
    annul = 1'b0;
    chk("annul_div_stall", {31'd0, stall_req}, 32'd0);
    no_done_window("annul_div", 40);
    @(negedge clk); issue(0, 32'd9, 32'd3, 1);             wait_done("after_annul_9_3", 33, 0);

    // back-to-back with start held across DONE
    @(negedge clk); issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_done("b2b_first", 33, 1);
    issue(0, 32'd5, 32'd10, 1);
    @(negedge clk);
    chk("b2b_idle_done", {31'd0, done}, 32'd0);
    wait_done("b2b_second", 33, 0);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk); issue(k[0], $urandom, $urandom_range(1, 32'h0001_FFFF), 1);
      wait_done("rand", 33, 0);
    end

    // reset after 20 iterations
    @(negedge clk); issue(1, 32'd1000, 32'd3, 0);
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("mid_rst_hi", result_hi, 32'd0);
    chk("mid_rst_lo", result_lo, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    no_done_window("mid_rst", 40);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
